mxu_sequencer: RTL and testbench
================================

// Module: mxu_sequencer
// PURPOSE
// Sequences one NxN signed matrix multiply C = A x B on the output-stationary systolic MXU for the
// instruction executor: fetches A and B from the scratchpad, drives the skewed north/west feeds
// and ce, then writes C back. Replaces ad-hoc stage counters in the executor with a
// valid/ready command port and a done pulse.
// PARAMETERS
// N       2   grid dimension; MXU is NxN
// W       16  word width, two's complement
// ADDR_W  5   scratchpad address width
// PORTS
// clk          in   1        clock
// rst          in   1        reset, asynchronous, active-high
// cmd_valid    in   1        command request
// cmd_ready    out  1        high only in IDLE
// cmd_a_addr   in   ADDR_W   base of A, row-major, N*N words
// cmd_b_addr   in   ADDR_W   base of B, row-major
// cmd_c_addr   in   ADDR_W   base of C result, row-major
// busy         out  1        high from accept until done inclusive
// done         out  1        one-cycle pulse after last C write
// mem_rd_en    out  1        scratchpad read strobe
// mem_rd_addr  out  ADDR_W   read address
// mem_rd_data  in   W        read data, valid exactly 1 cycle after mem_rd_en
// mem_wr_en    out  1        scratchpad write strobe
// mem_wr_addr  out  ADDR_W   write address
// mem_wr_data  out  W        write data
// mxu_clear    out  1        zero MXU accumulators
// mxu_ce       out  1        MXU step enable
// west_input   out  N*W      row i feed in bits [(i+1)W-1:iW]
// north_input  out  N*W      column j feed in bits [(j+1)W-1:jW]
// result_in    in   N*N*W    MXU accumulators; C[i][j] in slice k=i*N+j
// BEHAVIOUR
// - All outputs registered. Reset: state IDLE, cmd_ready=1, every other output 0, A/B regs 0.
// - Accept on cmd_valid && cmd_ready; latch three addresses; go to LOAD.
// - LOAD (2*N*N cycles): mxu_clear=1 in first cycle only. Reads issued back to back: A at
//   a_addr+k for k=0..N*N-1, then B at b_addr+k. Data captured 1 cycle later into A[k/N][k%N]
//   or B[k/N][k%N].
// - LOAD_WAIT (1 cycle): captures final B word; no read issued.
// - COMPUTE (3N-2 cycles, step t=0..3N-3): mxu_ce=1. west_input[i]=A[i][t-i] if 0<=t-i<N,
//   else 0; north_input[j]=B[t-j][j] if 0<=t-j<N, else 0.
// - SETTLE (1 cycle): mxu_ce=0, feeds 0; result_in stable from here on.
// - WRITE (N*N cycles): mem_wr_en=1, mem_wr_addr=c_addr+k, mem_wr_data=result slice k, k=0..N*N-1.
// - DONE (1 cycle): done=1, busy=1, cmd_ready=0; then IDLE. N=2 total: 8+1+4+1+4+1 = 19 cycles
//   after accept.
// - Address arithmetic wraps modulo 2^ADDR_W; no bounds check.
// - Overlap of C with A or B allowed: all reads complete before any write.
// - Values are passed through untouched; products and sums, including overflow wrap, are the MXU's job.
// - Never reads and writes in the same cycle; mem_rd_en and mem_wr_en are mutually exclusive.
// - cmd_valid while busy is ignored (not queued); held valid is accepted the cycle after DONE.
// - Reset mid-operation: immediate return to IDLE, in-flight write squashed, no done pulse.
// TESTING
// - A=[[1,2],[3,4]], B=[[5,6],[7,8]], a=0,b=4,c=8 -> mem[8..11]=19,22,43,50; done 19 cycles after accept.
// - A=[[-1,2],[3,-4]], B=identity -> C=[[-1,2],[3,-4]] (0xFFFF, 2, 3, 0xFFFC).
// - Check skew: COMPUTE t=0 west={0,A00} north={0,B00}; t=1 west={A10,A01} north={B01,B10}; t=3 all 0.
// - a_addr=30,b_addr=2,c_addr=31 (ADDR_W=5) -> reads 30,31,0,1; writes 31,0,1,2.
// - cmd_valid held high across two commands -> second accepted the cycle after done; cmd_ready 0 while busy.
// - rst asserted in COMPUTE t=2 -> next edge: IDLE, mxu_ce=0, no write, no done; new command runs normally.

Source files
------------

// File: rtl/mxu_sequencer.sv
// rtl/mxu_sequencer.sv - command-driven sequencer for one NxN matrix multiply on the systolic MXU
module mxu_sequencer #(
    parameter int N      = 2,
    parameter int W      = 16,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_a_addr,
    input  logic [ADDR_W-1:0]   cmd_b_addr,
    input  logic [ADDR_W-1:0]   cmd_c_addr,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic [W-1:0]        mem_rd_data,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [W-1:0]        mem_wr_data,
    output logic                mxu_clear,
    output logic                mxu_ce,
    output logic [N*W-1:0]      west_input,
    output logic [N*W-1:0]      north_input,
    input  logic [N*N*W-1:0]    result_in
);

    localparam int NN       = N * N;
    localparam int LOAD_LEN = 2 * NN;
    localparam int COMP_LEN = 3 * N - 2;
    localparam int CNT_W    = $clog2(LOAD_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_WAIT,
        S_COMPUTE,
        S_SETTLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   a_addr_q, a_addr_d;
    logic [ADDR_W-1:0]   b_addr_q, b_addr_d;
    logic [ADDR_W-1:0]   c_addr_q, c_addr_d;

    // Operand matrices, indexed [row][col]
    logic [N-1:0][N-1:0][W-1:0] a_q, a_d;
    logic [N-1:0][N-1:0][W-1:0] b_q, b_d;

    // Tracks which load index the scratchpad is returning this cycle
    logic                cap_valid_q;
    logic [CNT_W-1:0]    cap_idx_q;

    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_rd_addr_q, mem_rd_addr_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0]   mem_wr_addr_q, mem_wr_addr_d;
    logic [W-1:0]        mem_wr_data_q, mem_wr_data_d;
    logic                mxu_clear_q, mxu_clear_d;
    logic                mxu_ce_q, mxu_ce_d;
    logic [N*W-1:0]      west_q, west_d;
    logic [N*W-1:0]      north_q, north_d;

    // State, step counter and latched command addresses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            c_addr_q <= c_addr_d;
        end
    end

    // Phase sequencing: each phase runs a fixed number of steps counted by cnt
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        c_addr_d = c_addr_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d  = S_LOAD;
                    cnt_d    = '0;
                    a_addr_d = cmd_a_addr;
                    b_addr_d = cmd_b_addr;
                    c_addr_d = cmd_c_addr;
                end
            end
            S_LOAD: begin
                if (cnt_q == CNT_W'(LOAD_LEN - 1)) begin
                    state_d = S_LOAD_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOAD_WAIT: begin
                state_d = S_COMPUTE;
                cnt_d   = '0;
            end
            S_COMPUTE: begin
                if (cnt_q == CNT_W'(COMP_LEN - 1)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                state_d = S_WRITE;
                cnt_d   = '0;
            end
            S_WRITE: begin
                if (cnt_q == CNT_W'(NN - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Fold the returning read word into the operand matrices; feeds see it the same edge
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (cap_valid_q) begin
            for (int k = 0; k < NN; k++) begin
                if (cap_idx_q == CNT_W'(k)) begin
                    a_d[k / N][k % N] = mem_rd_data;
                end
                if (cap_idx_q == CNT_W'(NN + k)) begin
                    b_d[k / N][k % N] = mem_rd_data;
                end
            end
        end
    end

    // Operand storage and read-return tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            cap_valid_q <= (state_q == S_LOAD);
            cap_idx_q   <= cnt_q;
        end
    end

    // Output values for the phase being entered, so every output is a flop
    always_comb begin
        cmd_ready_d   = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
        mxu_clear_d   = (state_d == S_LOAD) && (cnt_d == '0);
        mem_rd_en_d   = (state_d == S_LOAD);
        mem_rd_addr_d = '0;
        mem_wr_en_d   = (state_d == S_WRITE);
        mem_wr_addr_d = '0;
        mem_wr_data_d = '0;
        mxu_ce_d      = (state_d == S_COMPUTE);
        west_d        = '0;
        north_d       = '0;

        // A words first, then B words, back to back
        if (state_d == S_LOAD) begin
            for (int k = 0; k < NN; k++) begin
                if (cnt_d == CNT_W'(k)) begin
                    mem_rd_addr_d = a_addr_d + ADDR_W'(k);
                end
                if (cnt_d == CNT_W'(NN + k)) begin
                    mem_rd_addr_d = b_addr_d + ADDR_W'(k);
                end
            end
        end

        // Skewed feeds: row i sees A[i][t-i], column j sees B[t-j][j]
        if (state_d == S_COMPUTE) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_d == CNT_W'(i + k)) begin
                        west_d[i*W +: W]  = a_d[i][k];
                        north_d[i*W +: W] = b_d[k][i];
                    end
                end
            end
        end

        // Accumulators are final from SETTLE onward
        if (state_d == S_WRITE) begin
            mem_wr_addr_d = c_addr_q + ADDR_W'(cnt_d);
            for (int k = 0; k < NN; k++) begin
                if (cnt_d == CNT_W'(k)) begin
                    mem_wr_data_d = result_in[k*W +: W];
                end
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            mxu_clear_q   <= 1'b0;
            mxu_ce_q      <= 1'b0;
            west_q        <= '0;
            north_q       <= '0;
        end else begin
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mxu_clear_q   <= mxu_clear_d;
            mxu_ce_q      <= mxu_ce_d;
            west_q        <= west_d;
            north_q       <= north_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign mxu_clear   = mxu_clear_q;
    assign mxu_ce      = mxu_ce_q;
    assign west_input  = west_q;
    assign north_input = north_q;

endmodule

// File: tb/tb_mxu_sequencer.sv
// tb/tb_mxu_sequencer.sv - directed self-checking bench for mxu_sequencer
module tb_mxu_sequencer;

    localparam int N      = 2;
    localparam int W      = 16;
    localparam int ADDR_W = 5;

    logic                clk;
    logic                rst;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_a_addr;
    logic [ADDR_W-1:0]   cmd_b_addr;
    logic [ADDR_W-1:0]   cmd_c_addr;
    logic                busy;
    logic                done;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_rd_addr;
    logic [W-1:0]        mem_rd_data;
    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic [W-1:0]        mem_wr_data;
    logic                mxu_clear;
    logic                mxu_ce;
    logic [N*W-1:0]      west_input;
    logic [N*W-1:0]      north_input;
    logic [N*N*W-1:0]    result_in;

    mxu_sequencer #(.N(N), .W(W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a_addr  (cmd_a_addr),
        .cmd_b_addr  (cmd_b_addr),
        .cmd_c_addr  (cmd_c_addr),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mxu_clear   (mxu_clear),
        .mxu_ce      (mxu_ce),
        .west_input  (west_input),
        .north_input (north_input),
        .result_in   (result_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratchpad: one-cycle read latency, plus a bench-side preload port
    logic [W-1:0]      mem [32];
    logic              tb_we;
    logic [ADDR_W-1:0] tb_wa;
    logic [W-1:0]      tb_wd;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (tb_we) mem[tb_wa] <= tb_wd;
        else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    // Output-stationary 2x2 systolic array model
    logic [W-1:0] acc   [2][2];
    logic [W-1:0] a_reg [2][2];
    logic [W-1:0] b_reg [2][2];

    always @(posedge clk or posedge rst) begin
        logic [W-1:0] ain, bin;
        int jm, im;
        if (rst || mxu_clear) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    acc[i][j]   <= '0;
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                end
        end else if (mxu_ce) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    jm = (j == 0) ? 0 : j - 1;
                    im = (i == 0) ? 0 : i - 1;
                    ain = (j == 0) ? west_input[i*W +: W] : a_reg[i][jm];
                    bin = (i == 0) ? north_input[j*W +: W] : b_reg[im][j];
                    acc[i][j]   <= acc[i][j] + W'(ain * bin);
                    a_reg[i][j] <= ain;
                    b_reg[i][j] <= bin;
                end
        end
    end

    assign result_in = {acc[1][1], acc[1][0], acc[0][1], acc[0][0]};

    int done_cnt    = 0;
    int overlap_cnt = 0;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;
    always @(negedge clk) if (mem_rd_en && mem_wr_en) overlap_cnt <= overlap_cnt + 1;

    int errors = 0;
    int checks = 0;

    // Per-cycle trace after an accept edge, cycle 1 = first cycle after accept
    logic              tr_rd_en   [64];
    logic [ADDR_W-1:0] tr_rd_addr [64];
    logic              tr_wr_en   [64];
    logic [ADDR_W-1:0] tr_wr_addr [64];
    logic              tr_ce      [64];
    logic              tr_clr     [64];
    logic [N*W-1:0]    tr_west    [64];
    logic [N*W-1:0]    tr_north   [64];
    logic              tr_busy    [64];
    logic              tr_rdy     [64];
    logic              tr_done    [64];
    int                done_at;
    int                rb_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
        tb_wa = a;
        tb_wd = d;
        tb_we = 1'b1;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic start_cmd(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                             input logic [ADDR_W-1:0] c);
        cmd_a_addr = a;
        cmd_b_addr = b;
        cmd_c_addr = c;
        cmd_valid  = 1'b1;
        chk("ready_before_accept", cmd_ready, 1);
        @(posedge clk);
    endtask

    task automatic trace(input int ncyc, input int drop_at);
        done_at = -1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            tr_rd_en[n]   = mem_rd_en;
            tr_rd_addr[n] = mem_rd_addr;
            tr_wr_en[n]   = mem_wr_en;
            tr_wr_addr[n] = mem_wr_addr;
            tr_ce[n]      = mxu_ce;
            tr_clr[n]     = mxu_clear;
            tr_west[n]    = west_input;
            tr_north[n]   = north_input;
            tr_busy[n]    = busy;
            tr_rdy[n]     = cmd_ready;
            tr_done[n]    = done;
            if (done && done_at < 0) done_at = n;
            if (cmd_ready && busy) rb_cnt++;
            if (n == drop_at) cmd_valid = 1'b0;
        end
    endtask

    task automatic load_t1();
        poke(5'd0, 16'd1); poke(5'd1, 16'd2); poke(5'd2, 16'd3); poke(5'd3, 16'd4);
        poke(5'd4, 16'd5); poke(5'd5, 16'd6); poke(5'd6, 16'd7); poke(5'd7, 16'd8);
    endtask

    task automatic check_t1_result(input string tag);
        chk({tag, "_c00"}, mem[8],  16'd19);
        chk({tag, "_c01"}, mem[9],  16'd22);
        chk({tag, "_c10"}, mem[10], 16'd43);
        chk({tag, "_c11"}, mem[11], 16'd50);
    endtask

    initial begin
        int dc;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_a_addr = '0;
        cmd_b_addr = '0;
        cmd_c_addr = '0;
        tb_we      = 1'b0;
        tb_wa      = '0;
        tb_wd      = '0;
        repeat (3) @(negedge clk);

        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_ce", mxu_ce, 0);
        chk("rst_clear", mxu_clear, 0);
        chk("rst_west", west_input, 0);
        chk("rst_north", north_input, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic product, skew and timing
        load_t1();
        start_cmd(5'd0, 5'd4, 5'd8);
        trace(22, 1);
        chk("t1_done_at", done_at, 19);
        for (int k = 0; k < 8; k++) begin
            chk("t1_rd_en", tr_rd_en[k+1], 1);
            chk("t1_rd_addr", tr_rd_addr[k+1], k);
        end
        chk("t1_rd_en_wait", tr_rd_en[9], 0);
        chk("t1_clear_first", tr_clr[1], 1);
        chk("t1_clear_second", tr_clr[2], 0);
        chk("t1_ce_wait", tr_ce[9], 0);
        chk("t1_ce_t0", tr_ce[10], 1);
        chk("t1_ce_t3", tr_ce[13], 1);
        chk("t1_ce_settle", tr_ce[14], 0);
        chk("t1_west_t0", tr_west[10], 32'h0000_0001);
        chk("t1_north_t0", tr_north[10], 32'h0000_0005);
        chk("t1_west_t1", tr_west[11], 32'h0003_0002);
        chk("t1_north_t1", tr_north[11], 32'h0006_0007);
        chk("t1_west_t2", tr_west[12], 32'h0004_0000);
        chk("t1_north_t2", tr_north[12], 32'h0008_0000);
        chk("t1_west_t3", tr_west[13], 0);
        chk("t1_north_t3", tr_north[13], 0);
        chk("t1_wr_settle", tr_wr_en[14], 0);
        for (int k = 0; k < 4; k++) begin
            chk("t1_wr_en", tr_wr_en[15+k], 1);
            chk("t1_wr_addr", tr_wr_addr[15+k], 8 + k);
        end
        chk("t1_wr_done", tr_wr_en[19], 0);
        chk("t1_busy_done", tr_busy[19], 1);
        chk("t1_ready_done", tr_rdy[19], 0);
        chk("t1_busy_after", tr_busy[20], 0);
        chk("t1_ready_after", tr_rdy[20], 1);
        chk("t1_done_cnt", done_cnt, 1);
        check_t1_result("t1");

        // Signed values through an identity
        poke(5'd16, 16'hFFFF); poke(5'd17, 16'd2); poke(5'd18, 16'd3); poke(5'd19, 16'hFFFC);
        poke(5'd20, 16'd1); poke(5'd21, 16'd0); poke(5'd22, 16'd0); poke(5'd23, 16'd1);
        start_cmd(5'd16, 5'd20, 5'd24);
        trace(22, 1);
        chk("t2_done_at", done_at, 19);
        chk("t2_c00", mem[24], 16'hFFFF);
        chk("t2_c01", mem[25], 16'd2);
        chk("t2_c10", mem[26], 16'd3);
        chk("t2_c11", mem[27], 16'hFFFC);

        // Address wrap with C overlapping B
        poke(5'd30, 16'd1); poke(5'd31, 16'd0); poke(5'd0, 16'd0); poke(5'd1, 16'd1);
        poke(5'd2, 16'd2); poke(5'd3, 16'd3); poke(5'd4, 16'd4); poke(5'd5, 16'd5);
        start_cmd(5'd30, 5'd2, 5'd31);
        trace(22, 1);
        chk("t3_rd0", tr_rd_addr[1], 30);
        chk("t3_rd1", tr_rd_addr[2], 31);
        chk("t3_rd2", tr_rd_addr[3], 0);
        chk("t3_rd3", tr_rd_addr[4], 1);
        chk("t3_rd4", tr_rd_addr[5], 2);
        chk("t3_rd7", tr_rd_addr[8], 5);
        chk("t3_wr0", tr_wr_addr[15], 31);
        chk("t3_wr1", tr_wr_addr[16], 0);
        chk("t3_wr2", tr_wr_addr[17], 1);
        chk("t3_wr3", tr_wr_addr[18], 2);
        chk("t3_c00", mem[31], 16'd2);
        chk("t3_c01", mem[0], 16'd3);
        chk("t3_c10", mem[1], 16'd4);
        chk("t3_c11", mem[2], 16'd5);

        // cmd_valid held across two commands
        load_t1();
        poke(5'd8, 16'd0); poke(5'd9, 16'd0); poke(5'd10, 16'd0); poke(5'd11, 16'd0);
        start_cmd(5'd0, 5'd4, 5'd8);
        trace(42, 21);
        chk("t4_done_at", done_at, 19);
        chk("t4_ready_busy", tr_rdy[10], 0);
        chk("t4_ready_done", tr_rdy[19], 0);
        chk("t4_ready_idle", tr_rdy[20], 1);
        chk("t4_busy_idle", tr_busy[20], 0);
        chk("t4_busy_second", tr_busy[21], 1);
        chk("t4_rd_second", tr_rd_en[21], 1);
        chk("t4_clear_second", tr_clr[21], 1);
        chk("t4_done_second", tr_done[39], 1);
        chk("t4_idle_second", tr_rdy[40], 1);
        check_t1_result("t4");

        // Reset during COMPUTE t=2
        poke(5'd8, 16'hAAAA); poke(5'd9, 16'hAAAA); poke(5'd10, 16'hAAAA); poke(5'd11, 16'hAAAA);
        start_cmd(5'd0, 5'd4, 5'd8);
        trace(12, 1);
        chk("t5_ce_before", tr_ce[12], 1);
        dc = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_ready", cmd_ready, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ce", mxu_ce, 0);
        chk("t5_rst_wr", mem_wr_en, 0);
        chk("t5_rst_rd", mem_rd_en, 0);
        chk("t5_rst_done", done, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_no_done", done_cnt, dc);
        chk("t5_no_write", mem[8], 16'hAAAA);
        start_cmd(5'd0, 5'd4, 5'd8);
        trace(22, 1);
        chk("t5_done_at", done_at, 19);
        check_t1_result("t5");

        chk("rd_wr_overlap", overlap_cnt, 0);
        chk("ready_while_busy", rb_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
